// File: rtl/fht_input_loader_if.sv
// Stream and bank-write bundle between the FHT input loader and its surroundings.
// master = the loader (drives ready, bank writes, start/busy/done); slave = upstream source and fht_control.
interface fht_input_loader_if #(
  parameter int A_BIT = 8,
  parameter int D_BIT = 16
);
  logic [D_BIT-1:0] data;
  logic             valid;
  logic             ready;
  logic [A_BIT-1:0] wr_addr;
  logic [D_BIT-1:0] wr_data;
  logic [3:0]       we;
  logic             start;
  logic             fht_rdy;
  logic             busy;
  logic             done;

  modport master (
    input  data, valid, fht_rdy,
    output ready, wr_addr, wr_data, we, start, busy, done
  );

  modport slave (
    output data, valid, fht_rdy,
    input  ready, wr_addr, wr_data, we, start, busy, done
  );
endinterface

// File: rtl/fht_input_loader.sv
// Loads one frame of 4*2^A_BIT samples into four banks in bit-reversed order,
// then starts fht_control and waits for the transform to finish.
module fht_input_loader #(
  parameter int A_BIT = 8,
  parameter int D_BIT = 16
) (
  input  logic                clk,
  input  logic                rst,
  fht_input_loader_if.master  bus,
  output logic [1:0]          dbg_state
);
  // Handshake: a sample is taken on a rising edge where valid and ready are both 1;
  // ready is registered, valid may toggle freely and is ignored while ready is 0.
  localparam int NW = A_BIT + 2;
  localparam logic [NW-1:0] N_LAST = '1;

  typedef enum logic [1:0] {
    LOAD     = 2'd0,
    START    = 2'd1,
    WAIT_RUN = 2'd2,
    WAIT_END = 2'd3
  } state_t;

  state_t        state;
  logic [NW-1:0] n;
  logic [NW-1:0] rev;

  always_comb begin
    rev = '0;
    for (int i = 0; i < NW; i++) begin
      rev[i] = n[NW-1-i];
    end
  end

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= LOAD;
      n           <= '0;
      bus.ready   <= 1'b0;
      bus.we      <= 4'b0000;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      bus.start   <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
    end else begin
      bus.we    <= 4'b0000;
      bus.start <= 1'b0;
      bus.done  <= 1'b0;
      case (state)
        LOAD: begin
          bus.ready <= 1'b1;
          if (bus.valid && bus.ready) begin
            // Top two reversed bits pick the bank, the rest the shared address.
            bus.we      <= 4'b0001 << rev[NW-1:NW-2];
            bus.wr_addr <= rev[A_BIT-1:0];
            bus.wr_data <= bus.data;
            if (n == N_LAST) begin
              n         <= '0;
              bus.ready <= 1'b0;
              bus.busy  <= 1'b1;
              state     <= START;
            end else begin
              n <= n + 1'b1;
            end
          end
        end
        START: begin
          bus.start <= 1'b1;
          state     <= WAIT_RUN;
        end
        // Ignore the ready level left over from before the start pulse.
        WAIT_RUN: begin
          if (!bus.fht_rdy) begin
            state <= WAIT_END;
          end
        end
        WAIT_END: begin
          if (bus.fht_rdy) begin
            bus.done  <= 1'b1;
            bus.ready <= 1'b1;
            bus.busy  <= 1'b0;
            state     <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule
